train_sequencer: RTL

Controller that sequences autoencoder training over the sample memory.
- Walks the sample memory and presents each word to the autoencoder datapath with a valid/ready handshake.
- Detects the end-of-sample marker, substitutes zero for it and flags it as the last word of the sample.
- After each sample, waits for the datapath to finish its weight update, counts the completed iteration, and stops after MAX_ITER iterations.

---
 rtl/train_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/train_sequencer.sv
// train_sequencer: walks sample memory, feeds words to the autoencoder datapath
// with valid/ready, and counts completed training iterations up to MAX_ITER.
module train_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int END_MARKER = 332,
  parameter int MAX_ITER   = 10000,
  parameter int ITER_W     = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_valid,
  output logic              dp_last,
  input  logic              dp_ready,
  input  logic              dp_done,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              finished
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, WAIT_DP, DONE} state_t;
  state_t state;
  logic [ITER_W-1:0] iter_next;
  logic              is_marker;
  assign iter_next = iter_count + ITER_W'(1);
  assign is_marker = mem_rdata == DATA_W'(END_MARKER);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      mem_addr   <= '0;
      dp_data    <= '0;
      dp_valid   <= 1'b0;
      dp_last    <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else if (abort && busy) begin
      state    <= IDLE;
      dp_valid <= 1'b0;
      dp_last  <= 1'b0;
      busy     <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (start && !abort) begin
            state      <= FETCH;
            mem_addr   <= '0;
            iter_count <= '0;
            busy       <= 1'b1;
            finished   <= 1'b0;
          end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          dp_data  <= is_marker ? '0 : mem_rdata;
          dp_last  <= is_marker;
          dp_valid <= 1'b1;
          state    <= PRESENT;
        end
        PRESENT:
          if (dp_ready) begin
            dp_valid <= 1'b0;
            mem_addr <= mem_addr == ADDR_W'(DATA_DEPTH - 1) ? '0 : mem_addr + ADDR_W'(1);
            state    <= dp_last ? WAIT_DP : FETCH;
          end
        WAIT_DP:
          if (dp_done) begin
            iter_count <= iter_next;
            state      <= iter_next == ITER_W'(MAX_ITER) ? DONE : FETCH;
            busy       <= iter_next != ITER_W'(MAX_ITER);
            finished   <= iter_next == ITER_W'(MAX_ITER);
          end
        default: state <= IDLE;
      endcase
endmodule
